// File: rtl/lsu_ram_master.sv
// lsu_ram_master: load/store initiator between the MEM stage and a doubleword RAM.
// Byte-addressed requests are mapped onto doubleword RAM accesses. Sub-doubleword
// stores become read-modify-write. Loads are extracted and sign/zero-extended here.
// The RAM port is always used at doubleword width (mem_wid_o = 3'b011).
// Optional feature macro: LSU_MISALIGN_SPLIT_EN. When it is defined, misaligned
// accesses are performed, and an access that crosses a doubleword boundary is
// split over two RAM accesses. When it is undefined, misaligned accesses fault.
module lsu_ram_master #(
  parameter int DATA_WIDTH = 64,
  parameter int RAM_SIZE   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_wid_i,
  input  logic [63:0]           req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_fault_o,
  output logic [RAM_SIZE-1:0]   mem_addr_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic [2:0]            mem_wid_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  mem_illegal_i
);

  localparam int       PW    = 2 * DATA_WIDTH;
  localparam logic [2:0] MEM_D = 3'b011;

  typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, RESP} state_t;

  state_t                state;
  logic                  op_we;
  logic [2:0]            op_wid;
  logic [2:0]            op_off;
  logic [DATA_WIDTH-1:0] op_wdata;
  logic [RAM_SIZE-1:0]   op_dw0;
  logic                  op_split;
  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;

  logic [2:0]            req_off;
  logic [RAM_SIZE-1:0]   req_dw0;
  logic                  req_misaligned;
  logic                  req_split;
  logic                  req_align_fault;
  logic                  req_fault;
  logic                  req_full_store;
  logic [PW-1:0]         live_pair;
  logic [PW-1:0]         merged;
  logic [DATA_WIDTH-1:0] rd_result;

  // The RAM is only ever driven at doubleword width.
  assign mem_wid_o = MEM_D;

  assign req_off = req_addr_i[2:0];
  assign req_dw0 = req_addr_i[RAM_SIZE+2:3];

  // Access size in bytes (1,2,4,8) from the low width bits.
  function automatic logic [3:0] size_bytes(input logic [2:0] wid);
    size_bytes = 4'd1 << wid[1:0];
  endfunction

  // Byte-shift the doubleword pair down to the access and extend to 64 bits.
  function automatic logic [DATA_WIDTH-1:0] extract(input logic [PW-1:0] pair,
                                                    input logic [2:0]    off,
                                                    input logic [2:0]    wid);
    logic [PW-1:0]         sh;
    logic [6:0]            nbits;
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] val;
    logic                  sign;
    sh    = pair >> {off, 3'b000};
    nbits = {size_bytes(wid), 3'b000};
    mask  = (DATA_WIDTH'(1) << nbits) - DATA_WIDTH'(1);
    val   = sh[DATA_WIDTH-1:0] & mask;
    sign  = sh[nbits-7'd1];
    if (!wid[2] && sign) begin
      val = val | ~mask;
    end
    extract = val;
  endfunction

  // Replace the accessed bytes of the doubleword pair with the store data LSBs.
  function automatic logic [PW-1:0] merge(input logic [PW-1:0]         pair,
                                          input logic [DATA_WIDTH-1:0] wdata,
                                          input logic [2:0]            off,
                                          input logic [2:0]            wid);
    logic [PW-1:0] mask;
    logic [PW-1:0] dat;
    mask  = ((PW'(1) << {size_bytes(wid), 3'b000}) - PW'(1)) << {off, 3'b000};
    dat   = {{DATA_WIDTH{1'b0}}, wdata} << {off, 3'b000};
    merge = (pair & ~mask) | (dat & mask);
  endfunction

  // Alignment check: offset must be a multiple of the access size.
  always_comb begin
    req_misaligned = 1'b0;
    case (req_wid_i[1:0])
      2'd1:    req_misaligned = req_off[0];
      2'd2:    req_misaligned = |req_off[1:0];
      2'd3:    req_misaligned = |req_off;
      default: req_misaligned = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [3:0] req_span;
  // Misalignment is legal; crossing the doubleword boundary needs a second access.
  always_comb begin
    req_span        = {1'b0, req_off} + size_bytes(req_wid_i);
    req_split       = (req_span > 4'd8);
    req_align_fault = 1'b0;
  end
`else
  // Without split support any misaligned access is a fault.
  always_comb begin
    req_split       = 1'b0;
    req_align_fault = req_misaligned;
  end
`endif

  // Decode faults and the read-free full doubleword store at accept time.
  always_comb begin
    req_fault = (req_wid_i == 3'b111)
              | (req_we_i & req_wid_i[2])
              | (|req_addr_i[63:RAM_SIZE+3])
              | req_align_fault;
    req_full_store = req_we_i && (req_wid_i == MEM_D) && (req_off == 3'd0);
  end

  // Doubleword pair as it will look once the current read lands in its buffer.
  always_comb begin
    if (state == RD1) begin
      live_pair = {mem_data_i, buf0};
    end else begin
      live_pair = {buf1, mem_data_i};
    end
    merged    = merge(live_pair, op_wdata, op_off, op_wid);
    rd_result = extract(live_pair, op_off, op_wid);
  end

  // Access sequencer with registered RAM and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_fault_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_read_o  <= 1'b0;
      mem_write_o <= 1'b0;
      mem_data_o  <= '0;
      op_we       <= 1'b0;
      op_wid      <= 3'b000;
      op_off      <= 3'b000;
      op_wdata    <= '0;
      op_dw0      <= '0;
      op_split    <= 1'b0;
      buf0        <= '0;
      buf1        <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      rsp_fault_o <= 1'b0;
      rsp_rdata_o <= '0;
      mem_read_o  <= 1'b0;
      mem_write_o <= 1'b0;
      case (state)
        IDLE: begin
          req_ready_o <= 1'b1;
          if (req_valid_i && req_ready_o) begin
            req_ready_o <= 1'b0;
            op_we       <= req_we_i;
            op_wid      <= req_wid_i;
            op_off      <= req_off;
            op_wdata    <= req_wdata_i;
            op_dw0      <= req_dw0;
            op_split    <= req_split;
            if (req_fault) begin
              state       <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_fault_o <= 1'b1;
            end else if (req_full_store) begin
              state       <= WR0;
              mem_write_o <= 1'b1;
              mem_addr_o  <= req_dw0;
              mem_data_o  <= req_wdata_i;
            end else begin
              state      <= RD0;
              mem_read_o <= 1'b1;
              mem_addr_o <= req_dw0;
            end
          end
        end
        RD0: begin
          if (mem_illegal_i) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_fault_o <= 1'b1;
          end else if (op_split) begin
            buf0       <= mem_data_i;
            state      <= RD1;
            mem_read_o <= 1'b1;
            mem_addr_o <= op_dw0 + 1'b1;
          end else if (op_we) begin
            {buf1, buf0} <= merged;
            state        <= WR0;
            mem_write_o  <= 1'b1;
            mem_addr_o   <= op_dw0;
            mem_data_o   <= merged[DATA_WIDTH-1:0];
          end else begin
            buf0        <= mem_data_i;
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= rd_result;
          end
        end
        RD1: begin
          if (mem_illegal_i) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_fault_o <= 1'b1;
          end else if (op_we) begin
            {buf1, buf0} <= merged;
            state        <= WR0;
            mem_write_o  <= 1'b1;
            mem_addr_o   <= op_dw0;
            mem_data_o   <= merged[DATA_WIDTH-1:0];
          end else begin
            buf1        <= mem_data_i;
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= rd_result;
          end
        end
        WR0: begin
          if (mem_illegal_i) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_fault_o <= 1'b1;
          end else if (op_split) begin
            state       <= WR1;
            mem_write_o <= 1'b1;
            mem_addr_o  <= op_dw0 + 1'b1;
            mem_data_o  <= buf1;
          end else begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
          end
        end
        WR1: begin
          state       <= RESP;
          rsp_valid_o <= 1'b1;
          rsp_fault_o <= mem_illegal_i;
        end
        RESP: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ram_master.sv
// Directed bench for lsu_ram_master: table of single requests against a
// behavioural doubleword RAM, plus reset-abort and back-to-back sequences.
module tb_lsu_ram_master;

  localparam int RS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_wid = 3'b000;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_fault;
  logic [RS-1:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_data;
  logic [2:0]  mem_wid;
  logic [63:0] mem_rdata;
  logic        mem_illegal;
  logic        ill_force = 1'b0;

  logic [63:0] ram [0:(1<<RS)-1];

  int tests = 0;
  int fails = 0;

  lsu_ram_master #(.DATA_WIDTH(64), .RAM_SIZE(RS)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_wid_i(req_wid), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_fault_o(rsp_fault),
    .mem_addr_o(mem_addr), .mem_read_o(mem_read), .mem_write_o(mem_write),
    .mem_data_o(mem_data), .mem_wid_o(mem_wid), .mem_data_i(mem_rdata),
    .mem_illegal_i(mem_illegal)
  );

  always #5 clk = ~clk;

  assign mem_rdata   = ram[mem_addr];
  assign mem_illegal = ill_force & (mem_read | mem_write);

  always @(posedge clk) begin
    if (mem_write && !mem_illegal) ram[mem_addr] <= mem_data;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [15:0] i0;
    logic [63:0] v0;
    logic [15:0] i1;
    logic [63:0] v1;
    logic        we;
    logic [2:0]  wid;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        ill;
    int          lat;
    logic [63:0] rdata;
    logic        fault;
    int          reads;
    int          writes;
    logic [15:0] a0;
    logic [63:0] c0;
    logic [63:0] c1;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string name, input logic [15:0] i0, input logic [63:0] v0,
                     input logic [15:0] i1, input logic [63:0] v1, input logic we,
                     input logic [2:0] wid, input logic [63:0] addr, input logic [63:0] wdata,
                     input logic ill, input int lat, input logic [63:0] rdata, input logic fault,
                     input int reads, input int writes, input logic [15:0] a0,
                     input logic [63:0] c0, input logic [63:0] c1);
    vec_t v;
    v.name = name; v.i0 = i0; v.v0 = v0; v.i1 = i1; v.v1 = v1; v.we = we; v.wid = wid;
    v.addr = addr; v.wdata = wdata; v.ill = ill; v.lat = lat; v.rdata = rdata;
    v.fault = fault; v.reads = reads; v.writes = writes; v.a0 = a0; v.c0 = c0; v.c1 = c1;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request from a negedge; return latency and observed RAM traffic.
  task automatic run_req(input logic we, input logic [2:0] wid, input logic [63:0] addr,
                         input logic [63:0] wdata, output int lat, output logic [63:0] rdata,
                         output logic fault, output int reads, output int writes,
                         output logic [15:0] a0, output int waits);
    bit got_addr;
    waits = 0; lat = -1; rdata = '0; fault = 1'b0; reads = 0; writes = 0; a0 = '0;
    got_addr = 0;
    while (!req_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    req_valid = 1'b1; req_we = we; req_wid = wid; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_read)  reads++;
      if (mem_write) writes++;
      if ((mem_read || mem_write) && !got_addr) begin
        a0 = mem_addr;
        got_addr = 1;
      end
      if (rsp_valid) begin
        lat = c; rdata = rsp_rdata; fault = rsp_fault;
        break;
      end
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_outs"}, {63'd0, req_ready, rsp_valid, rsp_fault, mem_read, mem_write},
          64'd0);
    check({name, "_rdata"}, rsp_rdata, 64'd0);
    check({name, "_maddr"}, {48'd0, mem_addr}, 64'd0);
    check({name, "_mdata"}, mem_data, 64'd0);
    check({name, "_mwid"}, {61'd0, mem_wid}, 64'd3);
  endtask

  int          lat, reads, writes, waits;
  logic [63:0] rdata;
  logic        fault;
  logic [15:0] a0;
  int          wr_seen;

  initial begin
    // Single-doubleword loads/stores, faults and RAM-illegal responses.
    add("LB",   2, 64'h80FF, 2, 64'h80FF, 0, 3'b000, 64'h10, 0, 0,
        2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 2, 64'h80FF, 64'h80FF);
    add("LBU",  2, 64'h80FF, 2, 64'h80FF, 0, 3'b100, 64'h11, 0, 0,
        2, 64'h80, 0, 1, 0, 2, 64'h80FF, 64'h80FF);
    add("LH",   2, 64'h80FF, 2, 64'h80FF, 0, 3'b001, 64'h10, 0, 0,
        2, 64'hFFFF_FFFF_FFFF_80FF, 0, 1, 0, 2, 64'h80FF, 64'h80FF);
    add("LWU",  2, 64'h8765_4321_0000_0000, 2, 64'h8765_4321_0000_0000, 0, 3'b110, 64'h14, 0, 0,
        2, 64'h8765_4321, 0, 1, 0, 2, 64'h8765_4321_0000_0000, 64'h8765_4321_0000_0000);
    add("LW",   2, 64'h8765_4321_0000_0000, 2, 64'h8765_4321_0000_0000, 0, 3'b010, 64'h14, 0, 0,
        2, 64'hFFFF_FFFF_8765_4321, 0, 1, 0, 2, 64'h8765_4321_0000_0000, 64'h8765_4321_0000_0000);
    add("LD",   3, 64'h0123_4567_89AB_CDEF, 3, 64'h0123_4567_89AB_CDEF, 0, 3'b011, 64'h18, 0, 0,
        2, 64'h0123_4567_89AB_CDEF, 0, 1, 0, 3, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    add("SH",   1, 64'h1122_3344_5566_7788, 1, 64'h1122_3344_5566_7788, 1, 3'b001, 64'h0A,
        64'hBEEF, 0, 3, 0, 0, 1, 1, 1, 64'h1122_3344_BEEF_7788, 64'h1122_3344_BEEF_7788);
    add("SB",   1, 64'h0, 1, 64'h0, 1, 3'b000, 64'h0F, 64'h12AB, 0,
        3, 0, 0, 1, 1, 1, 64'hAB00_0000_0000_0000, 64'hAB00_0000_0000_0000);
    add("SW",   1, 64'h1122_3344_5566_7788, 1, 64'h1122_3344_5566_7788, 1, 3'b010, 64'h08,
        64'hFFFF_FFFF_DEAD_BEEF, 0, 3, 0, 0, 1, 1, 1, 64'h1122_3344_DEAD_BEEF,
        64'h1122_3344_DEAD_BEEF);
    add("SD",   4, 64'h0, 4, 64'h0, 1, 3'b011, 64'h20, 64'hCAFE_F00D_1234_5678, 0,
        2, 0, 0, 0, 1, 4, 64'hCAFE_F00D_1234_5678, 64'hCAFE_F00D_1234_5678);
    add("F_SBU", 2, 64'h55, 2, 64'h55, 1, 3'b100, 64'h10, 64'hFF, 0,
        1, 0, 1, 0, 0, 0, 64'h55, 64'h55);
    add("F_W7", 2, 64'h55, 2, 64'h55, 0, 3'b111, 64'h10, 0, 0,
        1, 0, 1, 0, 0, 0, 64'h55, 64'h55);
    add("F_HI", 0, 64'h66, 0, 64'h66, 1, 3'b011, 64'h1 << (RS + 3), 64'h77, 0,
        1, 0, 1, 0, 0, 0, 64'h66, 64'h66);
    add("ILL_LD", 3, 64'h99, 3, 64'h99, 0, 3'b011, 64'h18, 0, 1,
        2, 0, 1, 1, 0, 3, 64'h99, 64'h99);
    add("ILL_SH", 1, 64'h1234, 1, 64'h1234, 1, 3'b001, 64'h0A, 64'hBEEF, 1,
        2, 0, 1, 1, 0, 1, 64'h1234, 64'h1234);
    add("ILL_SD", 5, 64'h4242, 5, 64'h4242, 1, 3'b011, 64'h28, 64'h1, 1,
        2, 0, 1, 0, 1, 5, 64'h4242, 64'h4242);
`ifdef LSU_MISALIGN_SPLIT_EN
    add("MIS_LW", 1, 64'hAABB_0000_0000_0000, 2, 64'hCCDD, 0, 3'b010, 64'h0E, 0, 0,
        3, 64'hFFFF_FFFF_CCDD_AABB, 0, 2, 0, 1, 64'hAABB_0000_0000_0000, 64'hCCDD);
    add("MIS_LH", 2, 64'h12_3400, 2, 64'h12_3400, 0, 3'b001, 64'h11, 0, 0,
        2, 64'h1234, 0, 1, 0, 2, 64'h12_3400, 64'h12_3400);
    add("MIS_SH", 2, 64'h0, 3, 64'h0, 1, 3'b001, 64'h17, 64'hBEEF, 0,
        5, 0, 0, 2, 2, 2, 64'hEF00_0000_0000_0000, 64'hBE);
`else
    add("MIS_LW", 1, 64'hAABB_0000_0000_0000, 2, 64'hCCDD, 0, 3'b010, 64'h0E, 0, 0,
        1, 0, 1, 0, 0, 0, 64'hAABB_0000_0000_0000, 64'hCCDD);
    add("MIS_LH", 2, 64'h12_3400, 2, 64'h12_3400, 0, 3'b001, 64'h11, 0, 0,
        1, 0, 1, 0, 0, 0, 64'h12_3400, 64'h12_3400);
    add("MIS_SH", 2, 64'h0, 3, 64'h0, 1, 3'b001, 64'h17, 64'hBEEF, 0,
        1, 0, 1, 0, 0, 0, 64'h0, 64'h0);
`endif

    // Reset state: outputs held at zero, ready rises after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", {63'd0, req_ready}, 64'd1);
    $display("[TB] reset release ready=%b", req_ready);

    foreach (vq[k]) begin
      ram[vq[k].i0] = vq[k].v0;
      ram[vq[k].i1] = vq[k].v1;
      ill_force = vq[k].ill;
      run_req(vq[k].we, vq[k].wid, vq[k].addr, vq[k].wdata, lat, rdata, fault, reads,
              writes, a0, waits);
      ill_force = 1'b0;
      $display("[TB] %s lat=%0d rdata=%h fault=%b rd=%0d wr=%0d", vq[k].name, lat, rdata,
               fault, reads, writes);
      check({vq[k].name, "_lat"}, 64'(lat), 64'(vq[k].lat));
      check({vq[k].name, "_rdata"}, rdata, vq[k].rdata);
      check({vq[k].name, "_fault"}, {63'd0, fault}, {63'd0, vq[k].fault});
      check({vq[k].name, "_reads"}, 64'(reads), 64'(vq[k].reads));
      check({vq[k].name, "_writes"}, 64'(writes), 64'(vq[k].writes));
      check({vq[k].name, "_addr0"}, {48'd0, a0}, {48'd0, vq[k].a0});
      @(negedge clk);
      check({vq[k].name, "_ram0"}, ram[vq[k].i0], vq[k].c0);
      check({vq[k].name, "_ram1"}, ram[vq[k].i1], vq[k].c1);
    end

    // Back-to-back: full store then load of the same doubleword.
    run_req(1'b1, 3'b011, 64'h20, 64'hFEED_FACE_0BAD_BEEF, lat, rdata, fault, reads, writes,
            a0, waits);
    $display("[TB] b2b SD lat=%0d fault=%b", lat, fault);
    check("b2b_sd_lat", 64'(lat), 64'd2);
    run_req(1'b0, 3'b011, 64'h20, 64'h0, lat, rdata, fault, reads, writes, a0, waits);
    $display("[TB] b2b LD lat=%0d rdata=%h waits=%0d", lat, rdata, waits);
    check("b2b_ld_wait", 64'(waits), 64'd1);
    check("b2b_ld_lat", 64'(lat), 64'd2);
    check("b2b_ld_rdata", rdata, 64'hFEED_FACE_0BAD_BEEF);

    // Reset during RD0 of a read-modify-write store: abort without writing.
    @(negedge clk);
    ram[1] = 64'h1122_3344_5566_7788;
    waits = 0;
    while (!req_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    req_valid = 1'b1; req_we = 1'b1; req_wid = 3'b001; req_addr = 64'h0A; req_wdata = 64'hBEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_mid_rd0", {63'd0, mem_read}, 64'd1);
    rst = 1'b1;
    #1;
    check_outputs_zero("rst_mid");
    wr_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_write) wr_seen++;
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_write || rsp_valid) wr_seen++;
    end
    check("rst_no_write", 64'(wr_seen), 64'd0);
    check("rst_ram_kept", ram[1], 64'h1122_3344_5566_7788);
    check("rst_ready", {63'd0, req_ready}, 64'd1);
    $display("[TB] reset mid-RD0 writes=%0d ready=%b", wr_seen, req_ready);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
